param_sequencer: RTL

PARAM_SEQUENCER -- requirements
Module: param_sequencer

---
 rtl/param_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/param_sequencer.sv
// param_sequencer: loads nine DATA_W parameters into a register bank.
// Optional watchdog enabled by defining PARAM_TIMEOUT_EN.
module param_sequencer #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dato_valid,
  input  logic [DATA_W-1:0]   dato_in,
  input  logic                listo_ht,
  output logic [3:0]          addr,
  output logic                en,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [9*DATA_W-1:0] params
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } state_t;

  state_t state;

`ifdef PARAM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_hit;

  // Watchdog terminal count reached this cycle.
  assign wd_hit = (wd_cnt == TERM);
`endif

  // Sequencer FSM with registered outputs and parameter bank.
  always_ff @(posedge clk) begin
    done        <= 1'b0;
    timeout_err <= 1'b0;
    if (rst) begin
      state  <= IDLE;
      addr   <= 4'd0;
      en     <= 1'b0;
      busy   <= 1'b0;
      params <= '0;
`ifdef PARAM_TIMEOUT_EN
      wd_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            addr  <= 4'd0;
            en    <= 1'b1;
            busy  <= 1'b1;
`ifdef PARAM_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        LOAD: begin
          if (dato_valid) begin
            for (int k = 0; k < 9; k++) begin
              if (addr == 4'(k))
                params[k*DATA_W +: DATA_W] <= dato_in;
            end
`ifdef PARAM_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            if (addr == 4'd8) begin
              addr  <= 4'd9;
              state <= FINISH;
            end else begin
              addr <= addr + 4'd1;
            end
          end
`ifdef PARAM_TIMEOUT_EN
          else if (wd_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            addr        <= 4'd0;
            en          <= 1'b0;
            busy        <= 1'b0;
            wd_cnt      <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        FINISH: begin
          if (listo_ht) begin
            done  <= 1'b1;
            state <= IDLE;
            addr  <= 4'd0;
            en    <= 1'b0;
            busy  <= 1'b0;
`ifdef PARAM_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
`ifdef PARAM_TIMEOUT_EN
          else if (wd_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            addr        <= 4'd0;
            en          <= 1'b0;
            busy        <= 1'b0;
            wd_cnt      <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          addr  <= 4'd0;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
